// File: rtl/serial_magnitude_comparator_if.sv
// Compare request/result bundle for the
// bit-serial magnitude comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             less;
  logic             greater;
  logic             equal;

  modport master (
    output start, a, b,
    input  busy, done, less, greater, equal
  );

  modport slave (
    input  start, a, b,
    output busy, done, less, greater, equal
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator,
// MSB-first, with start/busy/done handshake.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input logic clk,
  input logic reset,
  serial_magnitude_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             less;
  logic             greater;
  logic             equal;

  logic a_bit;
  logic b_bit;
  logic lt_nx;
  logic gt_nx;
  logic eq_nx;
  logic accept;
  logic finish;

  // Ripple one bit pair into the running flags.
  always_comb begin
    a_bit = sa[cnt];
    b_bit = sb[cnt];
    lt_nx = lt | (eq & ~a_bit & b_bit);
    gt_nx = gt | (eq & a_bit & ~b_bit);
    eq_nx = eq & ~(a_bit ^ b_bit);
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == '0 ||
            (EARLY_EXIT != 0 && !eq_nx)) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand capture, bit walk and result load.
  always_ff @(posedge clk) begin
    if (reset) begin
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      lt      <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b1;
      less    <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      cnt <= CW'(WIDTH - 1);
      lt  <= 1'b0;
      gt  <= 1'b0;
      eq  <= 1'b1;
    end else if (state == RUN) begin
      lt <= lt_nx;
      gt <= gt_nx;
      eq <= eq_nx;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        less    <= lt_nx;
        greater <= gt_nx;
        equal   <= eq_nx;
      end
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.less    = less;
  assign bus.greater = greater;
  assign bus.equal   = equal;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: early-exit and full-walk
// comparators driven side by side.
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  int checks = 0;
  int failures = 0;

  logic [2:0] prev [2];

  always #5 clk = ~clk;

  serial_magnitude_comparator_if #(.WIDTH(W)) bus_e ();
  serial_magnitude_comparator_if #(.WIDTH(W)) bus_f ();

  assign bus_e.start = start;
  assign bus_e.a     = a;
  assign bus_e.b     = b;
  assign bus_f.start = start;
  assign bus_f.a     = a;
  assign bus_f.b     = b;

  serial_magnitude_comparator #(
    .WIDTH(W),
    .EARLY_EXIT(1)
  ) dut_e (
    .clk(clk),
    .reset(reset),
    .bus(bus_e.slave)
  );

  serial_magnitude_comparator #(
    .WIDTH(W),
    .EARLY_EXIT(0)
  ) dut_f (
    .clk(clk),
    .reset(reset),
    .bus(bus_f.slave)
  );

  // d=1: early-exit DUT, d=0: full-walk DUT
  // packed as {busy, done, less, greater, equal}
  function automatic logic [4:0] obs(input int d);
    if (d == 1)
      return {bus_e.busy, bus_e.done, bus_e.less,
              bus_e.greater, bus_e.equal};
    return {bus_f.busy, bus_f.done, bus_f.less,
            bus_f.greater, bus_f.equal};
  endfunction

  function automatic int ref_lat(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input bit ee
  );
    if (!ee || x == y) return W;
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return W - i;
    return W;
  endfunction

  function automatic logic [2:0] ref_res(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    return {x < y, x > y, x == y};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    prev[0] = 3'b000;
    prev[1] = 3'b000;
  endtask

  // One compare on both DUTs; poke>0 raises start
  // again on that cycle with junk operands.
  task automatic run_cmp(
    input string        nm,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input int           poke
  );
    int         lat [2];
    logic [4:0] o;
    logic [1:0] eh;
    logic [2:0] er;
    a = x;
    b = y;
    start = 1'b1;
    tick;
    lat[0] = ref_lat(x, y, 1'b0);
    lat[1] = ref_lat(x, y, 1'b1);
    for (int c = 1; c <= W + 2; c++) begin
      start = (c == poke);
      a = W'($urandom);
      b = W'($urandom);
      tick;
      for (int d = 0; d < 2; d++) begin
        o  = obs(d);
        eh = {c < lat[d], c == lat[d]};
        er = (c >= lat[d]) ? ref_res(x, y) : prev[d];
        checks++;
        if (o[4:3] !== eh) begin
          failures++;
          $display("FAIL %s dut%0d hs c=%0d got=%b exp=%b",
                   nm, d, c, o[4:3], eh);
        end
        checks++;
        if (o[2:0] !== er) begin
          failures++;
          $display("FAIL %s dut%0d res c=%0d got=%b exp=%b",
                   nm, d, c, o[2:0], er);
        end
      end
    end
    start = 1'b0;
    prev[0] = ref_res(x, y);
    prev[1] = ref_res(x, y);
  endtask

  task automatic test_reset;
    do_reset;
    for (int c = 0; c < 5; c++) begin
      tick;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== 5'b0) begin
          failures++;
          $display("FAIL reset_idle dut%0d got=%b exp=%b",
                   d, obs(d), 5'b0);
        end
      end
    end
  endtask

  task automatic test_directed;
    run_cmp("eq_5a", 8'h5A, 8'h5A, 0);
    run_cmp("msb_80_7f", 8'h80, 8'h7F, 0);
    run_cmp("lsb_12_13", 8'h12, 8'h13, 0);
  endtask

  task automatic test_random;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           m;
    for (int n = 0; n < 24; n++) begin
      m = int'($urandom_range(0, 2));
      x = W'($urandom);
      if (m == 0)
        y = x;
      else if (m == 1)
        y = x ^ (W'(1) << $urandom_range(0, W - 1));
      else
        y = W'($urandom);
      run_cmp("random", x, y, 0);
    end
  endtask

  task automatic test_back_to_back;
    int got;
    do_reset;
    a = 8'h12;
    b = 8'h13;
    start = 1'b1;
    tick;
    start = 1'b0;
    got = -1;
    for (int c = 1; c <= W + 2; c++) begin
      tick;
      if (bus_e.done) begin
        got = c;
        break;
      end
    end
    checks++;
    if (got !== W) begin
      failures++;
      $display("FAIL b2b_first_lat got=%0d exp=%0d",
               got, W);
    end
    checks++;
    if (obs(1) !== 5'b01100) begin
      failures++;
      $display("FAIL b2b_first_res got=%b exp=%b",
               obs(1), 5'b01100);
    end
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (obs(1) !== 5'b10100) begin
      failures++;
      $display("FAIL b2b_no_idle got=%b exp=%b",
               obs(1), 5'b10100);
    end
    tick;
    checks++;
    if (obs(1) !== 5'b01010) begin
      failures++;
      $display("FAIL b2b_second got=%b exp=%b",
               obs(1), 5'b01010);
    end
    for (int c = 2; c <= W; c++) tick;
    checks++;
    if (obs(0) !== 5'b01010) begin
      failures++;
      $display("FAIL b2b_full_walk got=%b exp=%b",
               obs(0), 5'b01010);
    end
    tick;
    prev[0] = 3'b010;
    prev[1] = 3'b010;
  endtask

  task automatic test_start_in_run;
    run_cmp("start_in_run", 8'h00, 8'h00, 3);
  endtask

  task automatic test_reset_mid_run;
    int seen;
    do_reset;
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    checks++;
    if (obs(1) !== 5'b10000) begin
      failures++;
      $display("FAIL rst_mid_busy got=%b exp=%b",
               obs(1), 5'b10000);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs(d) !== 5'b0) begin
        failures++;
        $display("FAIL rst_mid dut%0d got=%b exp=%b",
                 d, obs(d), 5'b0);
      end
    end
    seen = 0;
    for (int c = 0; c < W + 2; c++) begin
      tick;
      if (obs(0) !== 5'b0 || obs(1) !== 5'b0)
        seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got=%0d exp=%0d",
               seen, 0);
    end
    prev[0] = 3'b000;
    prev[1] = 3'b000;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_start_in_run;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Bit-serial unsigned magnitude comparator. It walks two WIDTH-bit operands MSB-first, one bit per clock, and keeps running less/greater/eq flags using the per-bit ripple rule of the team's one-bit comparator stage. A start/busy/done handshake wraps the datapath so that a controller or ALU sequencer can issue compares and collect registered results. The block sits downstream of the operand registers and feeds flag consumers such as branch logic.

Parameters:
WIDTH, 8, operand width in bits (>=2)
EARLY_EXIT, 1, when 1, stop at the first differing bit; when 0, always run all WIDTH bits

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a compare; sampled only when accepting (IDLE or DONE)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid and updated in this cycle
less  output  1  registered result A<B
greater  output  1  registered result A>B
equal  output  1  registered result A==B

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, less=0, greater=0, equal=0; internal flags lt=0, gt=0, eq=1; bit counter=0; shift registers cleared.
- States:
  - IDLE: busy=0, done=0. On start=1: capture a and b into shift registers, set lt=0, gt=0, eq=1, cnt=WIDTH-1, go to RUN.
  - RUN: busy=1. Each edge consumes bit sa[cnt], sb[cnt]:
    - lt' = lt | (eq & ~a_bit & b_bit)
    - gt' = gt | (eq & a_bit & ~b_bit)
    - eq' = eq & ~(a_bit ^ b_bit)
    - Decrement cnt.
    - Go to DONE if cnt==0, or if EARLY_EXIT=1 and eq'==0.
    - On that edge, load less/greater/equal from lt'/gt'/eq'.
  - DONE: done=1 for exactly one cycle, busy=0. If start=1, accept a new compare exactly as from IDLE and go to RUN. Otherwise go to IDLE.
- Exactly one of less/greater/equal is 1 after any completed compare.
- Result outputs change only on the edge that enters DONE. They hold through subsequent RUN cycles and idle time until the next DONE.
- Latency: accepted start at edge N; done is high during the cycle after edge N+k.
  - k=WIDTH for equal operands or EARLY_EXIT=0.
  - Otherwise k = 1 + (WIDTH-1-i), where i is the index of the most-significant differing bit.
- Back-to-back: start held high in DONE gives zero idle cycles between compares.
- start during RUN is ignored. Operand inputs are don't-care except on the accepting edge.
- Reset asserted mid-RUN or in DONE aborts the compare. The next cycle shows reset values, with no done pulse.
- Operands are unsigned. The counter is clog2(WIDTH) bits wide and never wraps below 0; the cnt==0 exit takes priority.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, less=greater=equal=0 throughout.
- WIDTH=8, EARLY_EXIT=1, a=0x5A, b=0x5A, 1-cycle start -> busy for 8 cycles; done pulses 8 cycles after start edge; equal=1, less=0, greater=0.
- a=0x80, b=0x7F, EARLY_EXIT=1 -> done 1 cycle after start edge; greater=1. Same operands with EARLY_EXIT=0 -> done after 8 cycles; greater=1.
- a=0x12, b=0x13 -> LSB decides; done after 8 cycles; less=1. Then start held high in DONE with a=0xFF, b=0x00 -> next done 1 cycle later with greater=1, and no IDLE cycle in between.
- Pulse start again 3 cycles into a RUN (a=0x00, b=0x00 first) -> second start ignored; single done with equal=1; results unchanged until then.
- Assert reset 4 cycles into a RUN of a=0x01, b=0x02 -> next cycle busy=0 and all results 0; no done pulse appears afterwards.
